// File: rtl/psk_acq_pkg.sv
// Purpose: shared widths, parameter defaults and FSM state encoding for the
//          PSK acquisition controller and its energy pipeline.
package psk_acq_pkg;

  localparam int unsigned FCW_W  = 12;
  localparam int unsigned CORR_W = 8;
  localparam int unsigned E_W    = 16;
  localparam int unsigned LOSS_W = 4;

  localparam logic [FCW_W-1:0] FCW_START_DEF = 12'h0F0;
  localparam logic [FCW_W-1:0] FCW_STOP_DEF  = 12'h110;
  localparam logic [FCW_W-1:0] FCW_STEP_DEF  = 12'h004;
  localparam logic [FCW_W-1:0] PSTEP_DEF     = 12'd8;
  localparam logic [E_W-1:0]   THRESH_DEF    = 16'd4000;
  localparam int unsigned      LOSS_CNT_DEF  = 4;

  typedef enum logic [2:0] {
    IDLE,
    SWEEP_DISCARD,
    SWEEP_EVAL,
    DECIDE,
    TRACK
  } state_e;

endpackage

// File: rtl/iq_energy.sv
// Purpose: registers correlator window energy i*i+q*q together with a valid
//          strobe and the sign of I / value of Q for the phase detector.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   stb_i        window result valid on i_value_i / q_value_i
//   i_value_i    signed in-phase correlation
//   q_value_i    signed quadrature correlation
//   energy_o     registered energy, valid while e_vld_o is high
//   e_vld_o      one cycle after stb_i
//   i_pos_o      registered I > 0
//   i_neg_o      registered I < 0
//   q_value_o    registered Q
module iq_energy
  import psk_acq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stb_i,
  input  logic signed [CORR_W-1:0] i_value_i,
  input  logic signed [CORR_W-1:0] q_value_i,
  output logic        [E_W-1:0]    energy_o,
  output logic                     e_vld_o,
  output logic                     i_pos_o,
  output logic                     i_neg_o,
  output logic signed [CORR_W-1:0] q_value_o
);

  logic signed [E_W-1:0]    i_ext, q_ext, i_sq, q_sq;
  logic        [E_W-1:0]    energy_d;
  logic        [E_W-1:0]    energy_q;
  logic                     e_vld_q, i_pos_q, i_neg_q;
  logic signed [CORR_W-1:0] q_q;

  // Each square is at most 16384, so the unsigned sum (max 32768) fits E_W bits.
  assign i_ext    = E_W'(i_value_i);
  assign q_ext    = E_W'(q_value_i);
  assign i_sq     = i_ext * i_ext;
  assign q_sq     = q_ext * q_ext;
  assign energy_d = $unsigned(i_sq) + $unsigned(q_sq);

  // Window result pipeline stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      energy_q <= '0;
      e_vld_q  <= 1'b0;
      i_pos_q  <= 1'b0;
      i_neg_q  <= 1'b0;
      q_q      <= '0;
    end else begin
      e_vld_q <= stb_i;
      if (stb_i) begin
        energy_q <= energy_d;
        i_pos_q  <= !i_value_i[CORR_W-1] && (i_value_i != '0);
        i_neg_q  <= i_value_i[CORR_W-1];
        q_q      <= q_value_i;
      end
    end
  end

  assign energy_o  = energy_q;
  assign e_vld_o   = e_vld_q;
  assign i_pos_o   = i_pos_q;
  assign i_neg_o   = i_neg_q;
  assign q_value_o = q_q;

endmodule

// File: rtl/psk_acq_ctl.sv
// Purpose: PSK carrier acquisition controller. Sweeps the NCO frequency word,
//          keeps the strongest window, locks onto it if strong enough, then
//          tracks phase with a sign(I)*Q detector and drops lock after a run
//          of weak windows.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         begin acquisition (IDLE only)
//   stb_i           correlator window valid
//   i_value_i       signed in-phase correlation
//   q_value_i       signed quadrature correlation
//   fcw_o           NCO frequency control word
//   pcw_o           NCO phase control word
//   locked_o        high in TRACK
//   busy_o          high outside IDLE
//   no_lock_o       one-cycle pulse when a sweep ends below THRESH
//   best_energy_o   peak energy of the current or last sweep
module psk_acq_ctl
  import psk_acq_pkg::*;
#(
  parameter logic [FCW_W-1:0] FCW_START = FCW_START_DEF,
  parameter logic [FCW_W-1:0] FCW_STOP  = FCW_STOP_DEF,
  parameter logic [FCW_W-1:0] FCW_STEP  = FCW_STEP_DEF,
  parameter logic [E_W-1:0]   THRESH    = THRESH_DEF,
  parameter logic [FCW_W-1:0] PSTEP     = PSTEP_DEF,
  parameter int unsigned      LOSS_CNT  = LOSS_CNT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     stb_i,
  input  logic signed [CORR_W-1:0] i_value_i,
  input  logic signed [CORR_W-1:0] q_value_i,
  output logic        [FCW_W-1:0]  fcw_o,
  output logic        [FCW_W-1:0]  pcw_o,
  output logic                     locked_o,
  output logic                     busy_o,
  output logic                     no_lock_o,
  output logic        [E_W-1:0]    best_energy_o
);

  logic        [E_W-1:0]    energy;
  logic                     e_vld, i_pos, i_neg;
  logic signed [CORR_W-1:0] q_reg;

  iq_energy u_iq_energy (
    .clk       (clk),
    .rst       (rst),
    .stb_i     (stb_i),
    .i_value_i (i_value_i),
    .q_value_i (q_value_i),
    .energy_o  (energy),
    .e_vld_o   (e_vld),
    .i_pos_o   (i_pos),
    .i_neg_o   (i_neg),
    .q_value_o (q_reg)
  );

  state_e            state_q, state_d;
  logic [FCW_W-1:0]  fcw_q, fcw_d, pcw_q, pcw_d, best_fcw_q, best_fcw_d;
  logic [E_W-1:0]    best_q, best_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              no_lock_q, no_lock_d, locked_q, busy_q;

  // Sweep end test in FCW_W+1 bits so the word cannot wrap past FCW_STOP.
  logic [FCW_W:0] fcw_sum;
  logic           q_pos, q_neg, err_pos, err_neg;

  assign fcw_sum = {1'b0, fcw_q} + {1'b0, FCW_STEP};
  assign q_pos   = !q_reg[CORR_W-1] && (q_reg != '0);
  assign q_neg   = q_reg[CORR_W-1];
  assign err_pos = (i_pos && q_pos) || (i_neg && q_neg);
  assign err_neg = (i_pos && q_neg) || (i_neg && q_pos);

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    fcw_d      = fcw_q;
    pcw_d      = pcw_q;
    best_d     = best_q;
    best_fcw_d = best_fcw_q;
    loss_d     = loss_q;
    no_lock_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        fcw_d  = FCW_START;
        pcw_d  = '0;
        loss_d = '0;
        if (start_i) begin
          best_d     = '0;
          best_fcw_d = '0;
          state_d    = SWEEP_DISCARD;
        end
      end
      // The first window after a frequency change was integrated at the old word.
      SWEEP_DISCARD: begin
        if (e_vld) state_d = SWEEP_EVAL;
      end
      SWEEP_EVAL: begin
        if (e_vld) begin
          if (energy > best_q) begin
            best_d     = energy;
            best_fcw_d = fcw_q;
          end
          if (fcw_sum <= {1'b0, FCW_STOP}) begin
            fcw_d   = fcw_sum[FCW_W-1:0];
            state_d = SWEEP_DISCARD;
          end else begin
            state_d = DECIDE;
          end
        end
      end
      DECIDE: begin
        if (best_q >= THRESH) begin
          fcw_d   = best_fcw_q;
          pcw_d   = '0;
          loss_d  = '0;
          state_d = TRACK;
        end else begin
          no_lock_d = 1'b1;
          fcw_d     = FCW_START;
          state_d   = IDLE;
        end
      end
      TRACK: begin
        if (e_vld) begin
          if (err_pos)      pcw_d = pcw_q + PSTEP;
          else if (err_neg) pcw_d = pcw_q - PSTEP;
          if (energy >= THRESH) begin
            loss_d = '0;
          end else if (loss_q == LOSS_W'(LOSS_CNT - 1)) begin
            loss_d  = '0;
            fcw_d   = FCW_START;
            pcw_d   = '0;
            state_d = IDLE;
          end else begin
            loss_d = loss_q + LOSS_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fcw_q      <= FCW_START;
      pcw_q      <= '0;
      best_q     <= '0;
      best_fcw_q <= '0;
      loss_q     <= '0;
      no_lock_q  <= 1'b0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcw_q      <= fcw_d;
      pcw_q      <= pcw_d;
      best_q     <= best_d;
      best_fcw_q <= best_fcw_d;
      loss_q     <= loss_d;
      no_lock_q  <= no_lock_d;
      locked_q   <= (state_d == TRACK);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign fcw_o         = fcw_q;
  assign pcw_o         = pcw_q;
  assign locked_o      = locked_q;
  assign busy_o        = busy_q;
  assign no_lock_o     = no_lock_q;
  assign best_energy_o = best_q;

endmodule

// File: tb/tb_psk_acq_ctl.sv
// Purpose: directed self-checking bench for psk_acq_ctl.
module tb_psk_acq_ctl;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stb = 1'b0;
  logic signed [7:0] i_val = '0;
  logic signed [7:0] q_val = '0;
  logic [11:0]       fcw, pcw;
  logic              locked, busy, no_lock;
  logic [15:0]       best_energy;

  int checks = 0;
  int errors = 0;
  int nl_cnt = 0;
  int nl_base;

  psk_acq_ctl dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .stb_i         (stb),
    .i_value_i     (i_val),
    .q_value_i     (q_val),
    .fcw_o         (fcw),
    .pcw_o         (pcw),
    .locked_o      (locked),
    .busy_o        (busy),
    .no_lock_o     (no_lock),
    .best_energy_o (best_energy)
  );

  always #5 clk = ~clk;

  // Counts cycles with no_lock high.
  always @(negedge clk) if (no_lock) nl_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  // One correlator window, then two idle cycles so the FSM has acted on it.
  task automatic pulse(input logic signed [7:0] iv, input logic signed [7:0] qv);
    @(posedge clk); #1;
    stb = 1'b1; i_val = iv; q_val = qv;
    @(posedge clk); #1;
    stb = 1'b0;
    tick(2);
  endtask

  // One sweep point: a stale window followed by the evaluated one.
  task automatic point(input logic signed [7:0] iv, input logic signed [7:0] qv);
    pulse(8'sd5, 8'sd5);
    pulse(iv, qv);
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(2);
    #1 rst = 1'b0;
    tick(1);
    chk("rst_fcw", fcw, 12'h0F0);
    chk("rst_pcw", pcw, 12'h000);
    chk("rst_locked", locked, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_best", best_energy, 16'd0);
    chk("rst_nolock", no_lock, 1'b0);

    // Peak at 0x104, with fcw latency check on the first point
    do_start();
    chk("start_busy", busy, 1'b1);
    pulse(8'sd5, 8'sd5);
    @(posedge clk); #1 stb = 1'b1; i_val = 8'sd5; q_val = 8'sd5;
    @(posedge clk); #1 stb = 1'b0;
    chk("fcw_lat1", fcw, 12'h0F0);
    tick(1);
    chk("fcw_lat2", fcw, 12'h0F4);
    tick(1);
    for (int k = 1; k < 9; k++) begin
      if (k == 5) point(8'sd70, 8'sd0);
      else        point(8'sd5, 8'sd5);
    end
    tick(2);
    chk("peak_fcw", fcw, 12'h104);
    chk("peak_locked", locked, 1'b1);
    chk("peak_best", best_energy, 16'd4900);
    chk("peak_pcw", pcw, 12'h000);

    // Phase tracking, including wrap below zero
    for (int k = 0; k < 3; k++) pulse(8'sd70, 8'sd20);
    chk("trk_up", pcw, 12'd24);
    for (int k = 0; k < 4; k++) pulse(8'sd70, -8'sd20);
    chk("trk_wrap", pcw, 12'hFF8);
    chk("trk_locked", locked, 1'b1);

    // Loss counter: a strong window resets the run of weak ones
    for (int k = 0; k < 3; k++) pulse(8'sd0, 8'sd0);
    pulse(8'sd70, 8'sd0);
    for (int k = 0; k < 3; k++) pulse(8'sd0, 8'sd0);
    chk("loss3_locked", locked, 1'b1);
    chk("loss3_pcw", pcw, 12'hFF8);
    pulse(8'sd0, 8'sd0);
    chk("loss4_locked", locked, 1'b0);
    chk("loss4_busy", busy, 1'b0);
    chk("loss4_fcw", fcw, 12'h0F0);

    // No signal: weak everywhere
    nl_base = nl_cnt;
    do_start();
    for (int k = 0; k < 9; k++) point(8'sd10, 8'sd10);
    tick(3);
    chk("nosig_pulses", nl_cnt - nl_base, 1);
    chk("nosig_best", best_energy, 16'd200);
    chk("nosig_fcw", fcw, 12'h0F0);
    chk("nosig_busy", busy, 1'b0);
    chk("nosig_locked", locked, 1'b0);
    tick(5);
    chk("nosig_hold", best_energy, 16'd200);

    // Tie between 0x0F8 and 0x108 keeps the lower word
    do_start();
    chk("start_clr_best", best_energy, 16'd0);
    for (int k = 0; k < 9; k++) begin
      if (k == 2 || k == 6) point(8'sd70, 8'sd0);
      else                  point(8'sd5, 8'sd5);
    end
    tick(2);
    chk("tie_fcw", fcw, 12'h0F8);
    chk("tie_locked", locked, 1'b1);

    // start is ignored in TRACK
    do_start();
    tick(2);
    chk("trk_start_fcw", fcw, 12'h0F8);
    chk("trk_start_locked", locked, 1'b1);

    // Reset in TRACK aborts silently
    nl_base = nl_cnt;
    do_reset();
    chk("rst_trk_locked", locked, 1'b0);
    chk("rst_trk_busy", busy, 1'b0);
    chk("rst_trk_fcw", fcw, 12'h0F0);

    // start together with stb: that window must not be evaluated
    @(posedge clk); #1;
    start = 1'b1; stb = 1'b1; i_val = 8'sd100; q_val = 8'sd0;
    @(posedge clk); #1;
    start = 1'b0; stb = 1'b0;
    tick(2);
    chk("ss_busy", busy, 1'b1);
    chk("ss_fcw", fcw, 12'h0F0);
    chk("ss_best", best_energy, 16'd0);
    pulse(8'sd70, 8'sd0);
    chk("ss_eval_best", best_energy, 16'd4900);
    chk("ss_eval_fcw", fcw, 12'h0F4);

    // Reset mid-sweep at 0x100
    for (int k = 0; k < 3; k++) point(8'sd5, 8'sd5);
    chk("mid_fcw", fcw, 12'h100);
    do_reset();
    chk("mid_rst_fcw", fcw, 12'h0F0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_best", best_energy, 16'd0);
    chk("mid_rst_pcw", pcw, 12'h000);
    tick(3);
    chk("rst_no_pulse", nl_cnt - nl_base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
